rpn_token_sequencer: RTL and testbench
======================================

RPN_TOKEN_SEQUENCER -- requirements
Module: rpn_token_sequencer

Interface
REQ-001 Parameter: STACKDEPTH, default 32, the stack depth of the calculator this block drives.
REQ-002 Parameter: DW, fixed 32, the operand and result width.
REQ-003 Port: clock  input  1  the single clock; all logic is on its rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: tok_valid  input  1  a token is offered.
REQ-006 Port: tok_ready  output  1  the block accepts a token this cycle.
REQ-007 Port: tok_op  input  3  opcode: 0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 MUL, 6 PEEK, 7 CLEAR.
REQ-008 Port: tok_value  input  32  operand, used by PUSH only.
REQ-009 Port: calc_value  output  32  operand presented to the calculator.
REQ-010 Port: calc_push, calc_pop, calc_add, calc_sub, calc_mul  output  1 each  one-cycle command pulses to the calculator.
REQ-011 Port: calc_stack0  input  32  top of the calculator stack.
REQ-012 Port: res_valid  output  1  result available.
REQ-013 Port: res_ready  input  1  result consumer is ready.
REQ-014 Port: res_data  output  32  captured top of stack.
REQ-015 Port: depth  output  $clog2(STACKDEPTH+1)  tracked stack occupancy.
REQ-016 Port: err_underflow, err_overflow  output  1 each  sticky error flags.
REQ-017 Port: err_clear  input  1  clears both error flags.

Function
REQ-018 The block SHALL implement an FSM with the states IDLE, ISSUE, DRAIN and RESULT, and all outputs SHALL be registered.
REQ-019 tok_ready SHALL be 1 only in IDLE, and a token SHALL be accepted on an edge where tok_valid and tok_ready are both 1.
REQ-020 After an accepted PUSH, POP, ADD, SUB or MUL is judged legal, the block SHALL enter ISSUE and assert exactly one matching calc_* pulse for exactly one cycle.
REQ-021 During a PUSH pulse, calc_value SHALL equal the accepted tok_value; calc_value SHALL hold its last value otherwise.
REQ-022 ISSUE SHALL return to IDLE on the next edge, giving a throughput of one token per 2 cycles.
REQ-023 Legality and depth SHALL follow these rules:
- PUSH requires depth < STACKDEPTH; depth +1.
- POP requires depth >= 1; depth -1.
- ADD, SUB and MUL require depth >= 2; depth -1.
REQ-024 An illegal token SHALL be consumed with no pulse issued, depth unchanged, the matching err_* flag set, and the FSM passing through ISSUE.
REQ-025 NOP SHALL be consumed and pass through ISSUE with no pulse and no change.
REQ-026 PEEK SHALL pass through ISSUE with no pulse, and on the ISSUE-exit edge the block SHALL capture calc_stack0 into res_data, set res_valid and enter RESULT.
REQ-027 PEEK at depth 0 SHALL still return calc_stack0 and SHALL NOT flag an error.
REQ-028 RESULT SHALL hold res_valid and res_data stable until an edge where res_valid and res_ready are both 1, then clear res_valid and return to IDLE.
REQ-029 CLEAR SHALL enter DRAIN and assert calc_pop on consecutive cycles, decrementing depth per pulse, until depth reaches 0, then return to IDLE.
REQ-030 CLEAR at depth 0 SHALL issue no pulse and return to IDLE after one cycle in DRAIN.
REQ-031 At most one calc_* signal SHALL be high in any cycle.
REQ-032 err_clear SHALL zero both error flags on the next edge, except that an error raised on the same edge SHALL win and remain set.
REQ-033 depth SHALL saturate within 0..STACKDEPTH and never wrap.

Reset
REQ-034 While reset_n is 0, the block SHALL immediately (asynchronously) set:
- state to IDLE;
- tok_ready to 0;
- all calc_* pulses, calc_value, res_valid, res_data, depth, err_underflow and err_overflow to 0.
REQ-035 tok_ready SHALL rise in the first cycle after reset_n deasserts.
REQ-036 Reset asserted during ISSUE, DRAIN or RESULT SHALL abort the operation, drop any pulse in the same cycle, and discard any pending result.

Verification
REQ-037 PUSH 5, PUSH 7, ADD, PEEK, with res_ready=1 -> calc_push is seen twice, then calc_add once; res_data=12; depth=1.
REQ-038 PUSH 3, SUB, with depth=1 at the SUB -> no calc_sub pulse; err_underflow=1; depth stays 1; err_clear then clears the flag.
REQ-039 STACKDEPTH+1 PUSH tokens -> STACKDEPTH calc_push pulses; err_overflow=1; depth=STACKDEPTH.
REQ-040 CLEAR at depth=4 -> exactly 4 consecutive calc_pop cycles; depth=0; tok_ready high in the following cycle.
REQ-041 PEEK with res_ready held at 0 for 5 cycles -> res_valid and res_data stable and tok_ready=0 throughout; the result is released on the first edge with res_ready=1.
REQ-042 reset_n pulled low in the middle of a DRAIN -> calc_pop drops in the same cycle; depth=0; flags=0; the FSM is in IDLE after release.

Source files
------------

// File: rtl/rpn_token_sequencer.sv
// Token front-end for an RPN stack calculator: accepts one opcode per handshake,
// checks it against the tracked stack depth and drives the calculator command pulses.
module rpn_token_sequencer #(
  parameter int STACKDEPTH = 32,
  parameter int DW         = 32
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            tok_valid,
  output logic                            tok_ready,
  input  logic [2:0]                      tok_op,
  input  logic [DW-1:0]                   tok_value,
  output logic [DW-1:0]                   calc_value,
  output logic                            calc_push,
  output logic                            calc_pop,
  output logic                            calc_add,
  output logic                            calc_sub,
  output logic                            calc_mul,
  input  logic [DW-1:0]                   calc_stack0,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [DW-1:0]                   res_data,
  output logic [$clog2(STACKDEPTH+1)-1:0] depth,
  output logic                            err_underflow,
  output logic                            err_overflow,
  input  logic                            err_clear
);

  localparam int DEPW = $clog2(STACKDEPTH + 1);
  localparam logic [DEPW-1:0] MAX_DEPTH = DEPW'(STACKDEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESULT} state_e;
  typedef enum logic [2:0] {
    OP_NOP, OP_PUSH, OP_POP, OP_ADD, OP_SUB, OP_MUL, OP_PEEK, OP_CLEAR
  } op_e;

  state_e          state, state_d;
  op_e             op_q, op_d;
  logic            accept;
  logic            tok_ready_d, res_valid_d;
  logic            push_d, pop_d, add_d, sub_d, mul_d;
  logic [DW-1:0]   calc_value_d, res_data_d;
  logic [DEPW-1:0] depth_d;
  logic            set_udf, set_ovf;

  assign accept = tok_valid & tok_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      op_q          <= OP_NOP;
      tok_ready     <= 1'b0;
      calc_value    <= '0;
      calc_push     <= 1'b0;
      calc_pop      <= 1'b0;
      calc_add      <= 1'b0;
      calc_sub      <= 1'b0;
      calc_mul      <= 1'b0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      depth         <= '0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      state         <= state_d;
      op_q          <= op_d;
      tok_ready     <= tok_ready_d;
      calc_value    <= calc_value_d;
      calc_push     <= push_d;
      calc_pop      <= pop_d;
      calc_add      <= add_d;
      calc_sub      <= sub_d;
      calc_mul      <= mul_d;
      res_valid     <= res_valid_d;
      res_data      <= res_data_d;
      depth         <= depth_d;
      // A flag raised on this edge wins over a simultaneous clear.
      err_underflow <= (err_underflow & ~err_clear) | set_udf;
      err_overflow  <= (err_overflow & ~err_clear) | set_ovf;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (accept) state_d = (op_e'(tok_op) == OP_CLEAR) ? DRAIN : ISSUE;
      ISSUE:   state_d = (op_q == OP_PEEK) ? RESULT : IDLE;
      DRAIN:   if (depth == '0) state_d = IDLE;
      RESULT:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d         = accept ? op_e'(tok_op) : op_q;
    tok_ready_d  = (state_d == IDLE);
    calc_value_d = calc_value;
    push_d       = 1'b0;
    pop_d        = 1'b0;
    add_d        = 1'b0;
    sub_d        = 1'b0;
    mul_d        = 1'b0;
    res_valid_d  = res_valid;
    res_data_d   = res_data;
    depth_d      = depth;
    set_udf      = 1'b0;
    set_ovf      = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        unique case (op_e'(tok_op))
          OP_PUSH: if (depth < MAX_DEPTH) begin
            push_d       = 1'b1;
            calc_value_d = tok_value;
            depth_d      = depth + DEPW'(1);
          end else set_ovf = 1'b1;
          OP_POP: if (depth != '0) begin
            pop_d   = 1'b1;
            depth_d = depth - DEPW'(1);
          end else set_udf = 1'b1;
          OP_ADD, OP_SUB, OP_MUL: if (depth > DEPW'(1)) begin
            add_d   = (op_e'(tok_op) == OP_ADD);
            sub_d   = (op_e'(tok_op) == OP_SUB);
            mul_d   = (op_e'(tok_op) == OP_MUL);
            depth_d = depth - DEPW'(1);
          end else set_udf = 1'b1;
          // First drain pop is issued on the accept edge so pops run back to back.
          OP_CLEAR: if (depth != '0) begin
            pop_d   = 1'b1;
            depth_d = depth - DEPW'(1);
          end
          default: ;
        endcase
      end
      ISSUE: if (op_q == OP_PEEK) begin
        res_data_d  = calc_stack0;
        res_valid_d = 1'b1;
      end
      DRAIN: if (depth != '0) begin
        pop_d   = 1'b1;
        depth_d = depth - DEPW'(1);
      end
      RESULT: if (res_ready) res_valid_d = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rpn_token_sequencer.sv
// Directed bench for rpn_token_sequencer, with a small behavioural calculator
// stack that reacts to the command pulses and drives calc_stack0.
module tb_rpn_token_sequencer;
  localparam int SD   = 32;
  localparam int DEPW = $clog2(SD + 1);

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            tok_valid = 1'b0, tok_ready;
  logic [2:0]      tok_op = 3'd0;
  logic [31:0]     tok_value = '0, calc_value, calc_stack0, res_data;
  logic            calc_push, calc_pop, calc_add, calc_sub, calc_mul;
  logic            res_valid, res_ready = 1'b1;
  logic [DEPW-1:0] depth;
  logic            err_underflow, err_overflow, err_clear = 1'b0;

  int checks = 0, failures = 0;
  int push_cnt = 0, pop_cnt = 0, add_cnt = 0, sub_cnt = 0, multi_cnt = 0;
  logic [31:0] stk [0:63];
  int sp = 0;

  rpn_token_sequencer #(.STACKDEPTH(SD), .DW(32)) dut (
    .clock(clock), .reset_n(reset_n), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_op(tok_op), .tok_value(tok_value), .calc_value(calc_value),
    .calc_push(calc_push), .calc_pop(calc_pop), .calc_add(calc_add),
    .calc_sub(calc_sub), .calc_mul(calc_mul), .calc_stack0(calc_stack0),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .depth(depth), .err_underflow(err_underflow), .err_overflow(err_overflow),
    .err_clear(err_clear)
  );

  always #5 clock = ~clock;

  // Calculator model: acts on the pulses mid-cycle, ahead of the next edge.
  always @(negedge clock) begin
    if (!reset_n) sp = 0;
    else begin
      if (int'(calc_push) + int'(calc_pop) + int'(calc_add) + int'(calc_sub) + int'(calc_mul) > 1)
        multi_cnt++;
      push_cnt += int'(calc_push);
      pop_cnt  += int'(calc_pop);
      add_cnt  += int'(calc_add);
      sub_cnt  += int'(calc_sub);
      if (calc_push && sp < 64) begin stk[sp] = calc_value; sp++; end
      if (calc_pop && sp > 0) sp--;
      if ((calc_add || calc_sub || calc_mul) && sp >= 2) begin
        if (calc_add)      stk[sp-2] = stk[sp-2] + stk[sp-1];
        else if (calc_sub) stk[sp-2] = stk[sp-2] - stk[sp-1];
        else               stk[sp-2] = stk[sp-2] * stk[sp-1];
        sp--;
      end
    end
    calc_stack0 = (sp == 0) ? 32'hDEAD_BEEF : stk[sp-1];
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] val);
    int n = 0;
    while (tok_ready !== 1'b1 && n < 100) begin step(1); n++; end
    if (tok_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL send_wait: tok_ready=%b required 1", tok_ready);
    end
    tok_valid = 1'b1; tok_op = op; tok_value = val;
    step(1);
    tok_valid = 1'b0; tok_op = 3'd0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    push_cnt = 0; pop_cnt = 0; add_cnt = 0; sub_cnt = 0;
    step(1);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (tok_ready !== 1'b0 || res_valid !== 1'b0 || depth !== '0) begin
      failures++; $display("FAIL reset_outputs: ready=%b rv=%b depth=%0d required 0 0 0", tok_ready, res_valid, depth); end
    checks++; if ({calc_push, calc_pop, calc_add, calc_sub, calc_mul, err_underflow, err_overflow} !== 7'd0 || calc_value !== '0 || res_data !== '0) begin
      failures++; $display("FAIL reset_regs: pulses/errs=%b value=%0h data=%0h required 0", {calc_push, calc_pop, calc_add, calc_sub, calc_mul, err_underflow, err_overflow}, calc_value, res_data); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    step(1);
    checks++; if (tok_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_rise: tok_ready=%b required 1", tok_ready); end
  endtask

  task automatic test_add_peek();
    res_ready = 1'b1;
    send(3'd1, 32'd5);
    checks++; if (calc_push !== 1'b1 || calc_value !== 32'd5) begin
      failures++; $display("FAIL push_pulse: push=%b value=%0d required 1 5", calc_push, calc_value); end
    send(3'd1, 32'd7);
    checks++; if (calc_value !== 32'd7) begin failures++; $display("FAIL push_value: value=%0d required 7", calc_value); end
    send(3'd3, 32'd0);
    checks++; if (calc_add !== 1'b1) begin failures++; $display("FAIL add_pulse: add=%b required 1", calc_add); end
    send(3'd6, 32'd0);
    step(1);
    checks++; if (res_valid !== 1'b1 || res_data !== 32'd12) begin
      failures++; $display("FAIL peek_result: valid=%b data=%0d required 1 12", res_valid, res_data); end
    step(1);
    checks++; if (res_valid !== 1'b0 || tok_ready !== 1'b1) begin
      failures++; $display("FAIL peek_release: valid=%b ready=%b required 0 1", res_valid, tok_ready); end
    checks++; if (push_cnt !== 2 || add_cnt !== 1 || depth !== DEPW'(1)) begin
      failures++; $display("FAIL add_counts: pushes=%0d adds=%0d depth=%0d required 2 1 1", push_cnt, add_cnt, depth); end
  endtask

  task automatic test_underflow();
    apply_reset();
    send(3'd6, 32'd0);
    step(1);
    checks++; if (res_valid !== 1'b1 || res_data !== 32'hDEAD_BEEF || err_underflow !== 1'b0) begin
      failures++; $display("FAIL peek_empty: valid=%b data=%0h udf=%b required 1 deadbeef 0", res_valid, res_data, err_underflow); end
    step(1);
    send(3'd1, 32'd3);
    send(3'd4, 32'd0);
    checks++; if (calc_sub !== 1'b0 || err_underflow !== 1'b1 || depth !== DEPW'(1)) begin
      failures++; $display("FAIL sub_underflow: sub=%b udf=%b depth=%0d required 0 1 1", calc_sub, err_underflow, depth); end
    step(1);
    err_clear = 1'b1; step(1); err_clear = 1'b0;
    checks++; if (err_underflow !== 1'b0 || sub_cnt !== 0) begin
      failures++; $display("FAIL udf_clear: udf=%b subs=%0d required 0 0", err_underflow, sub_cnt); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < SD; i++) send(3'd1, 32'(i + 100));
    err_clear = 1'b1;
    send(3'd1, 32'd999);
    err_clear = 1'b0;
    checks++; if (err_overflow !== 1'b1 || calc_push !== 1'b0 || depth !== DEPW'(SD)) begin
      failures++; $display("FAIL overflow: ovf=%b push=%b depth=%0d required 1 0 %0d", err_overflow, calc_push, depth, SD); end
    step(1);
    checks++; if (push_cnt !== SD) begin failures++; $display("FAIL overflow_pushes: pushes=%0d required %0d", push_cnt, SD); end
    err_clear = 1'b1; step(1); err_clear = 1'b0;
    checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: ovf=%b required 0", err_overflow); end
  endtask

  task automatic test_clear();
    int run = 0;
    apply_reset();
    for (int i = 0; i < 4; i++) send(3'd1, 32'(i));
    step(1);
    send(3'd7, 32'd0);
    while (calc_pop === 1'b1 && run < 20) begin run++; step(1); end
    checks++; if (run !== 4 || pop_cnt !== 4) begin
      failures++; $display("FAIL clear_pops: run=%0d total=%0d required 4 4", run, pop_cnt); end
    checks++; if (depth !== '0 || tok_ready !== 1'b1) begin
      failures++; $display("FAIL clear_end: depth=%0d ready=%b required 0 1", depth, tok_ready); end
    send(3'd7, 32'd0);
    checks++; if (calc_pop !== 1'b0 || tok_ready !== 1'b0) begin
      failures++; $display("FAIL clear_empty_drain: pop=%b ready=%b required 0 0", calc_pop, tok_ready); end
    step(1);
    checks++; if (tok_ready !== 1'b1) begin failures++; $display("FAIL clear_empty_exit: ready=%b required 1", tok_ready); end
  endtask

  task automatic test_result_hold();
    int bad = 0;
    send(3'd1, 32'hA5A5_0001);
    res_ready = 1'b0;
    send(3'd6, 32'd0);
    step(1);
    checks++; if (res_valid !== 1'b1 || res_data !== 32'hA5A5_0001) begin
      failures++; $display("FAIL hold_start: valid=%b data=%0h required 1 a5a50001", res_valid, res_data); end
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (res_valid !== 1'b1 || res_data !== 32'hA5A5_0001 || tok_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL hold_stable: unstable_cycles=%0d required 0", bad); end
    res_ready = 1'b1;
    step(1);
    checks++; if (res_valid !== 1'b0 || tok_ready !== 1'b1) begin
      failures++; $display("FAIL hold_release: valid=%b ready=%b required 0 1", res_valid, tok_ready); end
  endtask

  task automatic test_reset_drain();
    apply_reset();
    send(3'd2, 32'd0);
    checks++; if (err_underflow !== 1'b1 || calc_pop !== 1'b0) begin
      failures++; $display("FAIL pop_empty: udf=%b pop=%b required 1 0", err_underflow, calc_pop); end
    for (int i = 0; i < 6; i++) send(3'd1, 32'(i));
    step(1);
    send(3'd7, 32'd0);
    step(2);
    checks++; if (calc_pop !== 1'b1) begin failures++; $display("FAIL drain_active: pop=%b required 1", calc_pop); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (calc_pop !== 1'b0 || depth !== '0 || err_underflow !== 1'b0 || err_overflow !== 1'b0 || tok_ready !== 1'b0) begin
      failures++; $display("FAIL drain_reset: pop=%b depth=%0d udf=%b ovf=%b ready=%b required 0 0 0 0 0", calc_pop, depth, err_underflow, err_overflow, tok_ready); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    step(1);
    checks++; if (tok_ready !== 1'b1) begin failures++; $display("FAIL drain_reset_idle: ready=%b required 1", tok_ready); end
    send(3'd0, 32'd0);
    checks++; if ({calc_push, calc_pop, calc_add, calc_sub, calc_mul} !== 5'd0 || tok_ready !== 1'b0) begin
      failures++; $display("FAIL nop_issue: pulses=%b ready=%b required 00000 0", {calc_push, calc_pop, calc_add, calc_sub, calc_mul}, tok_ready); end
    step(1);
    checks++; if (tok_ready !== 1'b1 || depth !== '0) begin
      failures++; $display("FAIL nop_exit: ready=%b depth=%0d required 1 0", tok_ready, depth); end
  endtask

  initial begin
    test_reset();
    test_add_peek();
    test_underflow();
    test_overflow();
    test_clear();
    test_result_hold();
    test_reset_drain();
    checks++; if (multi_cnt !== 0) begin failures++; $display("FAIL onehot_pulses: multi_cycles=%0d required 0", multi_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
